// File: rtl/instr_pkg.sv
// Shared definitions for the instruction fetch/sequencing stage: opcodes, IR field
// positions, condition-flag indices and FSM state encodings.
package instr_pkg;

  // Opcodes (0-11 are datapath ops, 22-31 reserved)
  localparam logic [4:0] OP_DATA_MAX = 5'd11;
  localparam logic [4:0] OP_JUMP     = 5'd12;
  localparam logic [4:0] OP_JCARRY   = 5'd13;
  localparam logic [4:0] OP_JNOCARRY = 5'd14;
  localparam logic [4:0] OP_JSIGN    = 5'd15;
  localparam logic [4:0] OP_JNOSIGN  = 5'd16;
  localparam logic [4:0] OP_JZERO    = 5'd17;
  localparam logic [4:0] OP_JNOZERO  = 5'd18;
  localparam logic [4:0] OP_JOVF     = 5'd19;
  localparam logic [4:0] OP_JNOOVF   = 5'd20;
  localparam logic [4:0] OP_HALT     = 5'd21;

  // IR field bit positions
  localparam int unsigned OPER_HI     = 31;
  localparam int unsigned OPER_LO     = 27;
  localparam int unsigned RDST_HI     = 26;
  localparam int unsigned RDST_LO     = 22;
  localparam int unsigned RSRC1_HI    = 21;
  localparam int unsigned RSRC1_LO    = 17;
  localparam int unsigned IMM_MODE    = 16;
  localparam int unsigned RSRC2_HI    = 15;
  localparam int unsigned RSRC2_LO    = 11;
  localparam int unsigned IMM_HI      = 15;
  localparam int unsigned IMM_LO      = 0;

  // Bit positions within flags_in = {sign, zero, overflow, carry}
  localparam int unsigned SIGN  = 3;
  localparam int unsigned ZERO  = 2;
  localparam int unsigned OVF   = 1;
  localparam int unsigned CARRY = 0;

  // FSM states
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] DECODE = 3'd3;
  localparam logic [2:0] ISSUE  = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  function automatic logic is_data_op(input logic [4:0] op);
    return op <= OP_DATA_MAX;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational jump classifier: flags which opcodes are jumps and whether the
// condition is satisfied by the current execute flags.
module branch_cond_eval
  import instr_pkg::*;
(
  input  logic [4:0] oper_type,
  input  logic [3:0] flags_in,
  output logic       is_jump,
  output logic       taken
);

  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    case (oper_type)
      OP_JUMP:     taken = 1'b1;
      OP_JCARRY:   taken = flags_in[CARRY];
      OP_JNOCARRY: taken = ~flags_in[CARRY];
      OP_JSIGN:    taken = flags_in[SIGN];
      OP_JNOSIGN:  taken = ~flags_in[SIGN];
      OP_JZERO:    taken = flags_in[ZERO];
      OP_JNOZERO:  taken = ~flags_in[ZERO];
      OP_JOVF:     taken = flags_in[OVF];
      OP_JNOOVF:   taken = ~flags_in[OVF];
      default:     is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencing stage: PC, IR, jump/halt resolution and issue handshake.
// Optional retired-instruction counter enabled by defining INSTR_FETCH_PERF_CNT_EN.
module instr_fetch_seq
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir_out,
  output logic               ir_valid,
  input  logic               ex_done,
  input  logic [3:0]         flags_in,
  output logic [ADDR_W-1:0]  pc_out,
`ifdef INSTR_FETCH_PERF_CNT_EN
  output logic [31:0]        retired_cnt,
`endif
  output logic               halted
);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pc_inc;
  logic [4:0]         oper_type;
  logic               is_jump;
  logic               taken;

  assign oper_type = ir_q[OPER_HI:OPER_LO];
  assign pc_inc    = pc_q + ADDR_W'(1);

  branch_cond_eval u_branch_cond_eval (
    .oper_type (oper_type),
    .flags_in  (flags_in),
    .is_jump   (is_jump),
    .taken     (taken)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        ir_d    = imem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        if (oper_type == OP_HALT) begin
          state_d = HALT;
        end else if (is_jump) begin
          // Only the low ADDR_W bits of imm form the target
          pc_d    = taken ? ir_q[IMM_LO +: ADDR_W] : pc_inc;
          state_d = FETCH;
        end else if (is_data_op(oper_type)) begin
          state_d = ISSUE;
        end else begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (ex_done) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end
      end
      HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        retire_evt;
  logic        restart;

  assign retire_evt = ((state_q == ISSUE) && ex_done) || ((state_q == DECODE) && is_jump);
  assign restart    = (state_q == HALT) && start;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (retire_evt && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_cnt = cnt_q;
`endif

  assign imem_addr  = pc_q;
  assign imem_rd_en = (state_q == FETCH);
  assign ir_out     = ir_q;
  assign ir_valid   = (state_q == ISSUE);
  assign pc_out     = pc_q;
  assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: jump vector table, directed corner sequences
// and a randomized program checked against an instruction-level reference model.
module tb_instr_fetch_seq;

  logic        clk;
  logic        sys_rst;
  logic        start;
  logic [7:0]  imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_rdata;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ex_done;
  logic [3:0]  flags_in;
  logic [7:0]  pc_out;
  logic        halted;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  instr_fetch_seq #(
    .ADDR_W  (8),
    .INSTR_W (32)
  ) dut (
    .clk         (clk),
    .sys_rst     (sys_rst),
    .start       (start),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_rdata  (imem_rdata),
    .ir_out      (ir_out),
    .ir_valid    (ir_valid),
    .ex_done     (ex_done),
    .flags_in    (flags_in),
    .pc_out      (pc_out),
`ifdef INSTR_FETCH_PERF_CNT_EN
    .retired_cnt (retired_cnt),
`endif
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [256];
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= imem[imem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [15:0] imm);
    return {op, 11'h2A5, imm};
  endfunction

  // Instruction-level model: the address executed after 'ins' at 'pc'.
  function automatic logic [7:0] ref_next(input logic [7:0] pc, input logic [31:0] ins,
                                          input logic [3:0] fl);
    int op = int'(ins[31:27]);
    int pos[4] = '{0, 3, 2, 1};
    int k;
    logic f;
    logic [7:0] seq = pc + 8'd1;
    if (op == 12) return ins[7:0];
    if (op >= 13 && op <= 20) begin
      k = op - 13;
      f = fl[pos[k / 2]];
      if ((k % 2) == 1) f = ~f;
      return f ? ins[7:0] : seq;
    end
    if (op == 21) return pc;
    return seq;
  endfunction

  task automatic do_reset();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs one instruction from its FETCH to the next FETCH (or HALT), checking timing.
  task automatic step(input logic [7:0] exp_addr, input logic [31:0] ins,
                      input logic [3:0] fl, input int dly, input bit noise,
                      output logic [7:0] nxt);
    int w = 0;
    int op = int'(ins[31:27]);
    flags_in = fl;
    while (!imem_rd_en && w < 20) begin
      tick();
      w++;
    end
    chk("fetch_seen", 32'(imem_rd_en), 32'd1);
    chk("fetch_addr", 32'(imem_addr), 32'(exp_addr));
    if (noise) begin ex_done = 1'($urandom); start = 1'($urandom); end
    tick();
    chk("load_ir_valid", 32'(ir_valid), 32'd0);
    chk("load_pc", 32'(pc_out), 32'(exp_addr));
    if (noise) begin ex_done = 1'($urandom); start = 1'($urandom); end
    tick();
    chk("decode_ir", ir_out, ins);
    chk("decode_ir_valid", 32'(ir_valid), 32'd0);
    ex_done = 1'b0;
    start   = 1'b0;
    tick();
    if (op <= 11) begin
      for (int i = 0; i <= dly; i++) begin
        chk("issue_ir_valid", 32'(ir_valid), 32'd1);
        chk("issue_ir", ir_out, ins);
        if (i == dly) ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
      end
      chk("issue_drop", 32'(ir_valid), 32'd0);
    end else if (op == 21) begin
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_ir_valid", 32'(ir_valid), 32'd0);
    end else begin
      chk("jump_no_valid", 32'(ir_valid), 32'd0);
      chk("jump_3cyc_fetch", 32'(imem_rd_en), 32'd1);
    end
    nxt = ref_next(exp_addr, ins, fl);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [15:0] imm;
    logic [3:0]  flags;
    logic [7:0]  exp_next;
  } vec_t;

  vec_t tbl[12];
  logic [7:0] nxt;
  logic [7:0] pc;
  int retired;

  initial begin
    sys_rst = 1'b1; start = 1'b0; ex_done = 1'b0; flags_in = 4'h0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0;

    tbl[0]  = '{5'd12, 16'h0033, 4'b0000, 8'h33};
    tbl[1]  = '{5'd17, 16'h0040, 4'b0100, 8'h40};
    tbl[2]  = '{5'd17, 16'h0040, 4'b0000, 8'h01};
    tbl[3]  = '{5'd13, 16'h1FF5, 4'b0001, 8'hF5};
    tbl[4]  = '{5'd14, 16'h0099, 4'b0001, 8'h01};
    tbl[5]  = '{5'd15, 16'h0077, 4'b1000, 8'h77};
    tbl[6]  = '{5'd16, 16'h0077, 4'b0111, 8'h77};
    tbl[7]  = '{5'd18, 16'h0055, 4'b0100, 8'h01};
    tbl[8]  = '{5'd19, 16'h0012, 4'b0010, 8'h12};
    tbl[9]  = '{5'd20, 16'h0021, 4'b0000, 8'h21};
    tbl[10] = '{5'd25, 16'h0066, 4'b1111, 8'h01};
    tbl[11] = '{5'd3,  16'h00AB, 4'b1111, 8'h01};

    // Reset state
    tick(); tick();
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_ir", ir_out, 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_pc", 32'(pc_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("rst_retired", retired_cnt, 32'd0);
`endif
    sys_rst = 1'b0;
    tick();
    chk("idle_no_fetch", 32'(imem_rd_en), 32'd0);

    // ADD with ex_done on the 2nd ISSUE cycle, then a taken JZERO at address 1
    imem[0] = mk(5'd0, 16'h1234);
    imem[1] = mk(5'd17, 16'h0040);
    do_start();
    step(8'h00, imem[0], 4'b0000, 1, 1'b0, nxt);
    step(8'h01, imem[1], 4'b0100, 0, 1'b0, nxt);
    chk("jzero_target", 32'(imem_addr), 32'h40);

    // Jump/data vector table, each instruction at address 0
    foreach (tbl[i]) begin
      do_reset();
      imem[0] = mk(tbl[i].op, tbl[i].imm);
      do_start();
      step(8'h00, imem[0], tbl[i].flags, 0, 1'b0, nxt);
      chk($sformatf("tbl%0d_fetch", i), 32'(imem_rd_en), 32'd1);
      chk($sformatf("tbl%0d_next", i), 32'(imem_addr), 32'(tbl[i].exp_next));
    end

    // PC wrap from 0xFF
    do_reset();
    imem[0]     = mk(5'd12, 16'h00FF);
    imem[8'hFF] = mk(5'd7, 16'h0001);
    do_start();
    step(8'h00, imem[0], 4'h0, 0, 1'b0, nxt);
    step(8'hFF, imem[8'hFF], 4'h0, 2, 1'b0, nxt);
    chk("wrap_addr", 32'(imem_addr), 32'h0);
    chk("wrap_fetch", 32'(imem_rd_en), 32'd1);

    // HALT at address 5 with stray start/ex_done pulses on the way
    do_reset();
    for (int i = 0; i < 5; i++) imem[i] = mk(5'(i), 16'(i));
    imem[5] = mk(5'd21, 16'h0000);
    do_start();
    for (int i = 0; i < 5; i++) step(8'(i), imem[i], 4'hF, i % 3, 1'b1, nxt);
    step(8'h05, imem[5], 4'h0, 0, 1'b1, nxt);
    tick(); tick();
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_pc_frozen", 32'(pc_out), 32'h05);
    chk("halt_no_fetch", 32'(imem_rd_en), 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("halt_retired", retired_cnt, 32'd5);
`endif
    do_start();
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_pc", 32'(pc_out), 32'd0);
    chk("restart_fetch", 32'(imem_rd_en), 32'd1);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("restart_retired", retired_cnt, 32'd0);
`endif

    // Reset during ISSUE with ex_done in the same cycle
    do_reset();
    imem[0] = mk(5'd2, 16'h0BAD);
    do_start();
    tick(); tick(); tick();
    chk("pre_rst_issue", 32'(ir_valid), 32'd1);
    sys_rst = 1'b1;
    ex_done = 1'b1;
    tick();
    chk("midrst_ir_valid", 32'(ir_valid), 32'd0);
    chk("midrst_ir", ir_out, 32'd0);
    chk("midrst_pc", 32'(pc_out), 32'd0);
    chk("midrst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("midrst_retired", retired_cnt, 32'd0);
`endif
    sys_rst = 1'b0;
    ex_done = 1'b0;
    tick();
    chk("midrst_idle", 32'(imem_rd_en), 32'd0);

    // Randomized program against the instruction-level model
    for (int i = 0; i < 256; i++) begin
      int r = $urandom_range(0, 99);
      logic [4:0] op;
      if (r < 50) op = 5'($urandom_range(0, 11));
      else if (r < 88) op = 5'($urandom_range(12, 20));
      else if (r < 95) op = 5'($urandom_range(22, 31));
      else op = 5'd21;
      imem[i] = {op, 11'($urandom), 16'($urandom)};
    end
    do_reset();
    do_start();
    pc = 8'h00;
    retired = 0;
    for (int n = 0; n < 300; n++) begin
      logic [4:0] op = imem[pc][31:27];
      step(pc, imem[pc], 4'($urandom), int'($urandom_range(0, 3)), 1'b1, nxt);
      if (op <= 5'd20) retired++;
      if (op == 5'd21) begin
        chk("rnd_halt_pc", 32'(pc_out), 32'(pc));
`ifdef INSTR_FETCH_PERF_CNT_EN
        chk("rnd_halt_retired", retired_cnt, 32'(retired));
`endif
        tick();
        do_start();
        chk("rnd_restart_halted", 32'(halted), 32'd0);
        nxt = 8'h00;
        retired = 0;
      end
      pc = nxt;
    end
    chk("rnd_final_fetch", 32'(imem_rd_en), 32'd1);
    chk("rnd_final_pc", 32'(imem_addr), 32'(pc));
`ifdef INSTR_FETCH_PERF_CNT_EN
    chk("rnd_final_retired", retired_cnt, 32'(retired));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
